// File: rtl/vx_dcache_req_throttle.sv
// Per-lane request throttle between the core data-cache bus and the L1 / shared memory.
// Requests pass through a 2-entry FIFO skid buffer; in-flight reads are capped at MAX_PENDING.
module vx_dcache_req_throttle #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 8,
  parameter int CTR_WIDTH   = 44
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              core_req_valid,
  input  logic                              core_req_rw,
  input  logic [ADDR_WIDTH-1:0]             core_req_addr,
  input  logic [DATA_WIDTH/8-1:0]           core_req_byteen,
  input  logic [DATA_WIDTH-1:0]             core_req_data,
  input  logic [TAG_WIDTH-1:0]              core_req_tag,
  output logic                              core_req_ready,
  output logic                              mem_req_valid,
  output logic                              mem_req_rw,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  output logic [DATA_WIDTH/8-1:0]           mem_req_byteen,
  output logic [DATA_WIDTH-1:0]             mem_req_data,
  output logic [TAG_WIDTH-1:0]              mem_req_tag,
  input  logic                              mem_req_ready,
  input  logic                              mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]              mem_rsp_tag,
  output logic                              mem_rsp_ready,
  output logic                              core_rsp_valid,
  output logic [DATA_WIDTH-1:0]             core_rsp_data,
  output logic [TAG_WIDTH-1:0]              core_rsp_tag,
  input  logic                              core_rsp_ready,
  output logic [$clog2(MAX_PENDING+1)-1:0]  pending_count,
  output logic [CTR_WIDTH-1:0]              perf_loads,
  output logic [CTR_WIDTH-1:0]              perf_stores,
  output logic [CTR_WIDTH-1:0]              perf_load_lat,
  output logic                              rsp_underflow,
  output logic                              busy
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int EW   = 1 + ADDR_WIDTH + BE_W + DATA_WIDTH + TAG_WIDTH;
  localparam int PW   = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_PENDING);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  state_e               state_q, state_d;
  logic [EW-1:0]        ent0_q, ent0_d;
  logic [EW-1:0]        ent1_q, ent1_d;
  logic                 rdy_q, rdy_d;
  logic [PW-1:0]        pend_q, pend_d;
  logic                 uflow_q, uflow_d;
  logic [CTR_WIDTH-1:0] loads_q, loads_d;
  logic [CTR_WIDTH-1:0] stores_q, stores_d;
  logic [CTR_WIDTH-1:0] lat_q, lat_d;

  logic          core_fire, issue_fire, rsp_fire, rd_issue;
  logic [EW-1:0] core_ent;

  assign core_ent = {core_req_rw, core_req_addr, core_req_byteen, core_req_data, core_req_tag};
  assign {mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag} = ent0_q;

  assign core_fire  = core_req_valid & core_req_ready;
  assign issue_fire = mem_req_valid & mem_req_ready;
  assign rsp_fire   = mem_rsp_valid & core_rsp_ready;
  assign rd_issue   = issue_fire & ~mem_req_rw;

  // Responses are a pure wire-through; only the fire is observed for accounting.
  assign mem_rsp_ready  = core_rsp_ready;
  assign core_rsp_valid = mem_rsp_valid;
  assign core_rsp_data  = mem_rsp_data;
  assign core_rsp_tag   = mem_rsp_tag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_EMPTY;
      ent0_q   <= '0;
      ent1_q   <= '0;
      rdy_q    <= 1'b0;
      pend_q   <= '0;
      uflow_q  <= 1'b0;
      loads_q  <= '0;
      stores_q <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      rdy_q    <= rdy_d;
      pend_q   <= pend_d;
      uflow_q  <= uflow_d;
      loads_q  <= loads_d;
      stores_q <= stores_d;
      lat_q    <= lat_d;
    end
  end

  // ent0 is always the head; ent1 only holds the younger entry in S_TWO.
  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case (state_q)
      S_EMPTY: begin
        if (core_fire) begin
          state_d = S_ONE;
          ent0_d  = core_ent;
        end
      end
      S_ONE: begin
        if (core_fire && issue_fire) begin
          ent0_d = core_ent;
        end else if (core_fire) begin
          state_d = S_TWO;
          ent1_d  = core_ent;
        end else if (issue_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (issue_fire) begin
          state_d = S_ONE;
          ent0_d  = ent1_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    rdy_d = (state_d != S_TWO);
  end

  // A read at the head waits for a free slot and holds back everything behind it.
  always_comb begin
    core_req_ready = rdy_q;
    mem_req_valid  = (state_q != S_EMPTY) && (mem_req_rw || (pend_q < MAX_P));
    busy           = (state_q != S_EMPTY) || (pend_q != '0);
    pending_count  = pend_q;
    rsp_underflow  = uflow_q;
    perf_loads     = loads_q;
    perf_stores    = stores_q;
    perf_load_lat  = lat_q;
  end

  always_comb begin
    pend_d  = pend_q;
    uflow_d = uflow_q;
    if (rd_issue && !rsp_fire) begin
      pend_d = pend_q + 1'b1;
    end else if (!rd_issue && rsp_fire) begin
      if (pend_q == '0) uflow_d = 1'b1;
      else              pend_d  = pend_q - 1'b1;
    end
    loads_d  = loads_q + CTR_WIDTH'(rd_issue);
    stores_d = stores_q + CTR_WIDTH'(issue_fire & mem_req_rw);
    lat_d    = lat_q + CTR_WIDTH'(pend_q);
  end

endmodule

// File: tb/tb_vx_dcache_req_throttle.sv
// Self-checking bench for vx_dcache_req_throttle: request order/fields via a scoreboard queue,
// throttle, stall, counters, underflow and mid-operation reset via per-scenario tasks.
module tb_vx_dcache_req_throttle;

  localparam int AW = 32, DW = 32, TW = 8, MP = 3, CW = 44, BW = 4, PW = 2;

  logic          clk;
  logic          reset;
  logic          core_req_valid, core_req_rw, core_req_ready;
  logic [AW-1:0] core_req_addr;
  logic [BW-1:0] core_req_byteen;
  logic [DW-1:0] core_req_data;
  logic [TW-1:0] core_req_tag;
  logic          mem_req_valid, mem_req_rw, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [BW-1:0] mem_req_byteen;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          core_rsp_valid, core_rsp_ready;
  logic [DW-1:0] core_rsp_data;
  logic [TW-1:0] core_rsp_tag;
  logic [PW-1:0] pending_count;
  logic [CW-1:0] perf_loads, perf_stores, perf_load_lat;
  logic          rsp_underflow, busy;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } req_t;

  req_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  vx_dcache_req_throttle #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP), .CTR_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw), .core_req_addr(core_req_addr),
    .core_req_byteen(core_req_byteen), .core_req_data(core_req_data), .core_req_tag(core_req_tag),
    .core_req_ready(core_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
    .core_rsp_ready(core_rsp_ready),
    .pending_count(pending_count), .perf_loads(perf_loads), .perf_stores(perf_stores),
    .perf_load_lat(perf_load_lat), .rsp_underflow(rsp_underflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: accepted requests are queued; every issue must match the oldest one exactly.
  always @(negedge clk) begin
    req_t t;
    req_t got;
    #2;
    if (reset && core_req_valid && core_req_ready) begin
      t = {core_req_rw, core_req_addr, core_req_byteen, core_req_data, core_req_tag};
      exp_q.push_back(t);
    end
    if (reset && mem_req_valid && mem_req_ready) begin
      got = {mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_order: issued %h with nothing outstanding", got);
      end else begin
        t = exp_q.pop_front();
        if (got !== t) begin
          bad++;
          $display("FAIL issue_fields: got %h required %h", got, t);
        end
      end
    end
  end

  task automatic set_req(input logic v, input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] tg);
    core_req_valid  = v;
    core_req_rw     = rw;
    core_req_addr   = a;
    core_req_byteen = a[3:0] ^ 4'hF;
    core_req_data   = {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    core_req_tag    = tg;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (core_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b required 0", core_req_ready); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid: got %b required 0", mem_req_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if ({pending_count, perf_loads, perf_stores, perf_load_lat, rsp_underflow} !== '0) begin
      bad++; $display("FAIL reset_counters: pend=%0d loads=%0d stores=%0d lat=%0d uf=%b required all 0",
                      pending_count, perf_loads, perf_stores, perf_load_lat, rsp_underflow);
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (core_req_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b required 1", core_req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (core_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, core_req_ready); end
      if (i > 0) begin
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b required 1", i, mem_req_valid); end
      end
      set_req(1'b1, 1'b1, 32'h100 + i, 8'h10 + 8'(i));
    end
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL b2b_last_valid: got %b required 1", mem_req_valid); end
    set_req(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy: got %b required 0", busy); end
    total++; if (perf_stores !== 44'd4) begin bad++; $display("FAIL b2b_stores: got %0d required 4", perf_stores); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_throttle;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_req(1'b1, 1'b0, 32'h200 + i, 8'h20 + 8'(i));
    end
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0);
    total++; if (pending_count !== 2'd3) begin bad++; $display("FAIL thr_pending: got %0d required 3", pending_count); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL thr_held: got %b required 0", mem_req_valid); end
    total++; if (core_req_ready !== 1'b1) begin bad++; $display("FAIL thr_ready: got %b required 1", core_req_ready); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL thr_still_held[%0d]: got %b required 0", i, mem_req_valid); end
    end
    core_rsp_ready = 1'b1;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = 32'hDEAD_0001;
    mem_rsp_tag    = 8'h21;
    #1;
    total++; if (core_rsp_valid !== 1'b1) begin bad++; $display("FAIL rsp_valid: got %b required 1", core_rsp_valid); end
    total++; if (core_rsp_data !== 32'hDEAD_0001) begin bad++; $display("FAIL rsp_data: got %h required DEAD0001", core_rsp_data); end
    total++; if (core_rsp_tag !== 8'h21) begin bad++; $display("FAIL rsp_tag: got %h required 21", core_rsp_tag); end
    total++; if (mem_rsp_ready !== 1'b1) begin bad++; $display("FAIL rsp_ready: got %b required 1", mem_rsp_ready); end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    total++; if (pending_count !== 2'd2) begin bad++; $display("FAIL thr_after_rsp: got %0d required 2", pending_count); end
    total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL thr_release: got %b required 1", mem_req_valid); end
    @(negedge clk);
    total++; if (pending_count !== 2'd3) begin bad++; $display("FAIL thr_reissue: got %0d required 3", pending_count); end
    total++; if (perf_loads !== 44'd4) begin bad++; $display("FAIL thr_loads: got %0d required 4", perf_loads); end
    mem_rsp_valid = 1'b1;
    repeat (3) @(negedge clk);
    mem_rsp_valid = 1'b0;
    total++; if (pending_count !== 2'd0) begin bad++; $display("FAIL thr_drain: got %0d required 0", pending_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL thr_busy: got %b required 0", busy); end
    total++; if (rsp_underflow !== 1'b0) begin bad++; $display("FAIL thr_uflow: got %b required 0", rsp_underflow); end
  endtask

  task automatic test_stall;
    @(negedge clk);
    mem_req_ready = 1'b0;
    set_req(1'b1, 1'b1, 32'h300, 8'h30);
    @(negedge clk);
    total++; if (core_req_ready !== 1'b1) begin bad++; $display("FAIL stall_ready1: got %b required 1", core_req_ready); end
    set_req(1'b1, 1'b0, 32'h301, 8'h31);
    @(negedge clk);
    total++; if (core_req_ready !== 1'b0) begin bad++; $display("FAIL stall_full: got %b required 0", core_req_ready); end
    set_req(1'b1, 1'b1, 32'h302, 8'h32);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (core_req_ready !== 1'b0) begin bad++; $display("FAIL stall_hold_ready[%0d]: got %b required 0", i, core_req_ready); end
      total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300) begin
        bad++; $display("FAIL stall_hold_head[%0d]: valid=%b addr=%h required 1/00000300", i, mem_req_valid, mem_req_addr);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if (core_req_ready !== 1'b1) begin bad++; $display("FAIL stall_reopen: got %b required 1", core_req_ready); end
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain: %0d left required 0", exp_q.size()); end
    total++; if (pending_count !== 2'd1) begin bad++; $display("FAIL stall_pending: got %0d required 1", pending_count); end
    total++; if (perf_loads !== 44'd5 || perf_stores !== 44'd6) begin
      bad++; $display("FAIL stall_ctrs: loads=%0d stores=%0d required 5/6", perf_loads, perf_stores);
    end
  endtask

  task automatic test_same_cycle;
    logic [CW-1:0] lat0;
    @(negedge clk);
    set_req(1'b1, 1'b0, 32'h400, 8'h40);
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0);
    total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL same_valid: got %b required 1", mem_req_valid); end
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 8'h31;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    total++; if (pending_count !== 2'd1) begin bad++; $display("FAIL same_pending: got %0d required 1", pending_count); end
    total++; if (perf_loads !== 44'd6) begin bad++; $display("FAIL same_loads: got %0d required 6", perf_loads); end
    lat0 = perf_load_lat;
    repeat (10) @(negedge clk);
    total++; if ((perf_load_lat - lat0) !== 44'd10) begin
      bad++; $display("FAIL load_lat_delta: got %0d required 10", perf_load_lat - lat0);
    end
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    total++; if (pending_count !== 2'd0 || rsp_underflow !== 1'b0) begin
      bad++; $display("FAIL same_drain: pend=%0d uf=%b required 0/0", pending_count, rsp_underflow);
    end
  endtask

  task automatic test_underflow;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 8'h5A;
    #1;
    total++; if (core_rsp_tag !== 8'h5A) begin bad++; $display("FAIL uf_tag: got %h required 5a", core_rsp_tag); end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    total++; if (rsp_underflow !== 1'b1) begin bad++; $display("FAIL uf_set: got %b required 1", rsp_underflow); end
    total++; if (pending_count !== 2'd0) begin bad++; $display("FAIL uf_pending: got %0d required 0", pending_count); end
    repeat (3) @(negedge clk);
    total++; if (rsp_underflow !== 1'b1 || pending_count !== 2'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL uf_sticky: uf=%b pend=%0d busy=%b required 1/0/0", rsp_underflow, pending_count, busy);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_req(1'b1, 1'b0, 32'h500 + i, 8'h50 + 8'(i));
    end
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0);
    total++; if (core_req_ready !== 1'b0 || pending_count !== 2'd3 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_setup: ready=%b pend=%0d busy=%b required 0/3/1", core_req_ready, pending_count, busy);
    end
    #3;
    reset = 1'b0;
    #1;
    total++; if (core_req_ready !== 1'b0 || mem_req_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_async_ctrl: ready=%b valid=%b busy=%b required 0/0/0", core_req_ready, mem_req_valid, busy);
    end
    total++; if ({pending_count, perf_loads, perf_stores, perf_load_lat, rsp_underflow} !== '0) begin
      bad++; $display("FAIL mid_async_ctrs: pend=%0d loads=%0d stores=%0d lat=%0d uf=%b required all 0",
                      pending_count, perf_loads, perf_stores, perf_load_lat, rsp_underflow);
    end
    total++; if (mem_req_addr !== 32'h0) begin bad++; $display("FAIL mid_async_addr: got %h required 0", mem_req_addr); end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (core_req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_release: ready=%b busy=%b required 1/0", core_req_ready, busy);
    end
    total++; if ({pending_count, perf_loads, perf_stores, perf_load_lat} !== '0) begin
      bad++; $display("FAIL mid_release_ctrs: pend=%0d loads=%0d stores=%0d lat=%0d required all 0",
                      pending_count, perf_loads, perf_stores, perf_load_lat);
    end
  endtask

  initial begin
    reset          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    mem_rsp_tag    = '0;
    core_rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, '0, '0);
    test_reset();
    test_back_to_back();
    test_throttle();
    test_stall();
    test_same_cycle();
    test_underflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
